// File: rtl/alu_pkg.sv
// Shared types for the multicycle ALU: opcodes, FSM states and the NZCV flag bundle.
// No logic here; latency and backpressure are defined by the users of these types.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'h0,
        OP_EOR = 4'h1,
        OP_SUB = 4'h2,
        OP_ADD = 4'h4,
        OP_ADC = 4'h5,
        OP_LSL = 4'h8,
        OP_LSR = 4'h9,
        OP_ASR = 4'hA,
        OP_ORR = 4'hC,
        OP_MUL = 4'hE
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } estado_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU ops and NZCV flags; purely combinational, zero latency.
// No backpressure: outputs follow the inputs; MUL is handled by the caller.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  op_e              op_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] res_o,
    output flags_t           flags_o,
    output logic             illegal_o
);
    localparam int SW = $clog2(WIDTH);
    localparam int M  = WIDTH - 1;

    logic [SW-1:0]  amt;
    logic [WIDTH:0] sum, dif, shl, shr, sra;
    logic           c, v;

    // Shifts run one bit wider so the last bit shifted out lands in the extra bit;
    // an amount of zero leaves that bit at 0, which is exactly the required carry.
    always_comb begin
        amt = b_i[SW-1:0];
        sum = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, (op_i == OP_ADC) & cin_i};
        dif = {1'b0, a_i} - {1'b0, b_i};
        shl = {1'b0, a_i} << amt;
        shr = {a_i, 1'b0} >> amt;
        sra = $unsigned($signed({a_i, 1'b0}) >>> amt);

        res_o     = '0;
        c         = 1'b0;
        v         = 1'b0;
        illegal_o = 1'b0;
        case (op_i)
            OP_AND: res_o = a_i & b_i;
            OP_EOR: res_o = a_i ^ b_i;
            OP_ORR: res_o = a_i | b_i;
            OP_ADD, OP_ADC: begin
                res_o = sum[M:0];
                c     = sum[WIDTH];
                v     = (a_i[M] == b_i[M]) && (res_o[M] != a_i[M]);
            end
            OP_SUB: begin
                res_o = dif[M:0];
                c     = ~dif[WIDTH];
                v     = (a_i[M] != b_i[M]) && (res_o[M] != a_i[M]);
            end
            OP_LSL: begin
                res_o = shl[M:0];
                c     = shl[WIDTH];
            end
            OP_LSR: begin
                res_o = shr[WIDTH:1];
                c     = shr[0];
            end
            OP_ASR: begin
                res_o = sra[WIDTH:1];
                c     = sra[0];
            end
            OP_MUL:  res_o = '0;
            default: illegal_o = 1'b1;
        endcase
        flags_o = '{n: res_o[M], z: (res_o == '0), c: c, v: v};
    end

endmodule

// File: rtl/alu_multiciclo.sv
// Handshaked ALU: 1 cycle for single-cycle ops, WIDTH+1 cycles for shift-add MUL.
// Accepts only in IDLE; result and flags are held in DONE until out_ready.
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] datoA,
    input  logic [WIDTH-1:0] datoB,
    input  logic [3:0]       opCode,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] salida,
    output logic             negative,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             illegal
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int M  = WIDTH - 1;

    estado_e          state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    flags_t           flags_q, flags_d;
    logic             ill_q, ill_d;

    op_e              op;
    logic [WIDTH-1:0] comb_res;
    flags_t           comb_flags;
    logic             comb_ill;

    assign op = op_e'(opCode);

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .a_i       (datoA),
        .b_i       (datoB),
        .op_i      (op),
        .cin_i     (cin),
        .res_o     (comb_res),
        .flags_o   (comb_flags),
        .illegal_o (comb_ill)
    );

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        flags_d   = flags_q;
        ill_d     = ill_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (op == OP_MUL) begin
                        mcand_d  = datoA;
                        mplier_d = datoB;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
                        res_d   = comb_res;
                        flags_d = comb_flags;
                        ill_d   = comb_ill;
                        state_d = DONE;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Final iteration retires straight into the output registers.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    res_d   = acc_d;
                    flags_d = '{n: acc_d[M], z: (acc_d == '0), c: 1'b0, v: 1'b0};
                    ill_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            flags_q  <= '0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
            ill_q    <= ill_d;
        end
    end

    assign salida   = res_q;
    assign negative = flags_q.n;
    assign zero     = flags_q.z;
    assign cout     = flags_q.c;
    assign overflow = flags_q.v;
    assign illegal  = ill_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed-vector bench for alu_multiciclo with hand-computed results and flags.
module tb_alu_multiciclo;
    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, cin;
    logic        in_ready, out_valid;
    logic [31:0] datoA, datoB, salida;
    logic [3:0]  opCode;
    logic        negative, zero, cout, overflow, illegal;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_multiciclo #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .datoA     (datoA),
        .datoB     (datoB),
        .opCode    (opCode),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .salida    (salida),
        .negative  (negative),
        .zero      (zero),
        .cout      (cout),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Issue one op with out_ready high; measures accept-edge-inclusive latency.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic ci, input logic [31:0] er,
                          input logic [3:0] ef, input logic ei, input int elat);
        int cyc;
        chk({tag, "/in_ready"}, in_ready, 1);
        opCode = op; datoA = a; datoB = b; cin = ci; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            // Stray requests while busy must not disturb the running op.
            if (cyc == 5 || cyc == 9) begin
                in_valid = 1'b1; opCode = 4'h4; datoA = 32'h1111_1111; datoB = 32'h2;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, "/latency"}, cyc, elat);
        chk({tag, "/salida"}, salida, er);
        chk({tag, "/nzcv"}, {negative, zero, cout, overflow}, ef);
        chk({tag, "/illegal"}, illegal, ei);
        @(posedge clk); #1;
        chk({tag, "/done_1cyc"}, out_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; cin = 1'b0;
        opCode = 4'h4; datoA = 32'hDEAD_BEEF; datoB = 32'h1;
        #12;
        chk("rst/in_ready", in_ready, 1);
        chk("rst/out_valid", out_valid, 0);
        chk("rst/salida", salida, 0);
        chk("rst/flags_ill", {negative, zero, cout, overflow, illegal}, 5'b0);
        @(posedge clk); #1;
        in_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_ovf",  4'h4, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 4'b1001, 1'b0, 1);
        run_op("add_wrap", 4'h4, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0,         4'b0110, 1'b0, 1);
        run_op("adc_cin",  4'h5, 32'hFFFF_FFFE, 32'h1, 1'b1, 32'h0,         4'b0110, 1'b0, 1);
        run_op("adc_small",4'h5, 32'h1,         32'h2, 1'b1, 32'h4,         4'b0000, 1'b0, 1);
        run_op("sub_eq",   4'h2, 32'h5,         32'h5, 1'b0, 32'h0,         4'b0110, 1'b0, 1);
        run_op("sub_neg",  4'h2, 32'h3,         32'h5, 1'b0, 32'hFFFF_FFFE, 4'b1000, 1'b0, 1);
        run_op("asr1",     4'hA, 32'h8000_0001, 32'h1, 1'b0, 32'hC000_0000, 4'b1010, 1'b0, 1);
        run_op("lsl0",     4'h8, 32'h1234_5678, 32'h20,1'b0, 32'h1234_5678, 4'b0000, 1'b0, 1);
        run_op("lsl1",     4'h8, 32'h8000_0001, 32'h1, 1'b0, 32'h0000_0002, 4'b0010, 1'b0, 1);
        run_op("lsr2",     4'h9, 32'h3,         32'h2, 1'b0, 32'h0,         4'b0110, 1'b0, 1);
        run_op("orr",      4'hC, 32'h0F,        32'hF0,1'b0, 32'hFF,        4'b0000, 1'b0, 1);
        run_op("and",      4'h0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 32'h0F00_0F00, 4'b0000, 1'b0, 1);
        run_op("mul",      4'hE, 32'h0001_0001, 32'h0001_0001, 1'b0, 32'h0002_0001, 4'b0000, 1'b0, 33);
        run_op("mul_m1",   4'hE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h1,         4'b0000, 1'b0, 33);
        run_op("illegal3", 4'h3, 32'h1234,      32'h5678,      1'b0, 32'h0,         4'b0100, 1'b1, 1);

        // Consumer stalls in DONE: everything must hold.
        out_ready = 1'b0;
        opCode = 4'h1; datoA = 32'hF0F0_F0F0; datoB = 32'hFF00_FF00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("stall/valid0", out_valid, 1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("stall/valid", out_valid, 1);
            chk("stall/salida", salida, 32'h0FF0_0FF0);
            chk("stall/in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall/release", out_valid, 0);

        // Reset in the middle of a multiply discards it.
        opCode = 4'hE; datoA = 32'h3; datoB = 32'h4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("midrst/out_valid", out_valid, 0);
        chk("midrst/in_ready", in_ready, 1);
        chk("midrst/salida", salida, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("midrst/no_late_valid", out_valid, 0);
        run_op("post_rst", 4'h4, 32'h10, 32'h20, 1'b0, 32'h30, 4'b0000, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_multiciclo.md
# alu_multiciclo

Parametrised, handshaked ALU for the datapath execute stage: the next generation of the single-cycle 32-bit AND/SUB/ADD unit. It adds a configurable width, OR/EOR/ADC/shift/multiply operations and a full registered NZCV flag set. Single-cycle operations complete in one clock. Multiply runs as an iterative shift-add sequence, and valid/ready handshakes on both sides let the control unit stall on it.

## Interface
- `WIDTH`, 32, operand/result width (≥ 8, power of two)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operands/opcode valid
- `in_ready`  out  1  unit can accept a new operation
- `datoA`, `datoB`  in  WIDTH  operands
- `opCode`  in  4  operation select
- `cin`  in  1  carry-in (ADC only)
- `out_valid`  out  1  `salida`/flags valid
- `out_ready`  in  1  consumer takes result
- `salida`  out  WIDTH  registered result
- `negative`, `zero`, `cout`, `overflow`  out  1  registered N/Z/C/V
- `illegal`  out  1  opcode not in the operation list

## Operation
- Opcodes:
  - 0x0 AND, 0x1 EOR, 0x2 SUB (A−B), 0x4 ADD, 0x5 ADC (A+B+cin), 0xC ORR
  - 0x8 LSL, 0x9 LSR, 0xA ASR; shift amount = `datoB[$clog2(WIDTH)-1:0]`
  - 0xE MUL; low WIDTH bits of A×B
- Any other opcode: `salida`=0, Z=1, N=C=V=0, `illegal`=1. Otherwise `illegal`=0.
- Flags:
  - N = `salida[WIDTH-1]`; Z = (`salida`==0).
  - ADD/ADC: C = carry out of the MSB; V = signed overflow.
  - SUB: C = NOT borrow (1 when A ≥ B unsigned); V = signed overflow.
  - Shifts: C = last bit shifted out; C=0 when the amount is 0.
  - Logic ops and MUL: C=0, V=0.
- FSM states:
  - IDLE: `in_ready`=1. `in_valid` latches operands/opcode. A non-MUL opcode goes to DONE with the result computed at the accepting edge. MUL goes to MUL with accumulator=0, counter=0.
  - MUL: each cycle, if multiplier LSB is 1, accumulator += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, counter++. After WIDTH iterations go to DONE.
  - DONE: `out_valid`=1. Result and flags are held stable. `out_ready` returns to IDLE.
- `in_ready`=1 only in IDLE, so the unit accepts no new operation while one is in flight.

## Timing
- Reset (async assert, synchronous-release use): state=IDLE, `in_ready`=1, `out_valid`=0, `salida`=0, N=C=V=0, Z=0, `illegal`=0, MUL counter/accumulator=0.
- Reset mid-MUL or in DONE aborts the operation; the result is discarded.
- Latency (accept edge to `out_valid` high):
  - non-MUL: 1 cycle
  - MUL: WIDTH+1 cycles
- Handshake completes on the edge where `out_valid` && `out_ready`.
- Earliest next accept is one cycle after that edge, since the FSM must be back in IDLE.
- `out_ready` held high before `out_valid` rises: DONE lasts exactly one cycle.
- `in_valid` while not in IDLE is ignored; the driver holds it until `in_ready`.
- The counter must never exceed WIDTH. MUL arithmetic is modulo 2^WIDTH, so upper product bits are dropped.

## Structure
- Package `alu_pkg`:
  - `op_e` opcode enum
  - `estado_e` FSM enum (IDLE, MUL, DONE)
  - `flags_t` packed struct {n, z, c, v}
- Sub-module `alu_comb`, parametrised by WIDTH: pure combinational single-cycle op and flag computation. The top holds the FSM, operand registers, multiply datapath and output registers.

## Test plan
- Reset with `in_valid`=1 → `in_ready`=1, `out_valid`=0, all outputs 0.
- ADD 0x7FFFFFFF + 1 → after 1 cycle: `salida`=0x80000000, N=1, Z=0, C=0, V=1.
- SUB 5 − 5 → `salida`=0, Z=1, C=1, V=0. Then SUB 3 − 5 → 0xFFFFFFFE, N=1, C=0.
- ASR 0x80000001 by 1 → 0xC0000000, C=1. LSL by 0 → operand unchanged, C=0.
- MUL 0x10001 × 0x10001 → `out_valid` exactly 33 cycles after accept, `salida`=0x00020001. `in_valid` pulses during MUL are ignored.
- `out_ready` low for 4 cycles in DONE → outputs stable. Opcode 0x3 → `illegal`=1, Z=1. Reset asserted mid-MUL → IDLE, `out_valid`=0.
